// File: rtl/uart_rx_if.sv
// uart_rx_if: line-side input and host-side result signals of the UART receiver.
// master = line driver / host consumer, slave = the receiver itself.
// Optional macro UART_RX_PARITY_EN adds the uart_rx_parity_err signal.
interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;
`ifdef UART_RX_PARITY_EN
  logic                    uart_rx_parity_err;

  modport master (
    output uart_rxd, uart_rx_en,
    input  uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break,
           uart_rx_parity_err
  );

  modport slave (
    input  uart_rxd, uart_rx_en,
    output uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break,
           uart_rx_parity_err
  );
`else
  modport master (
    output uart_rxd, uart_rx_en,
    input  uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break
  );

  modport slave (
    input  uart_rxd, uart_rx_en,
    output uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Synchronises the RX pin, qualifies the start bit at
// its centre, then samples every following bit one bit period apart.
// A completed frame is reported with a one-cycle valid strobe plus error flags.
// Optional macro UART_RX_PARITY_EN: adds an even-parity bit between payload
// and stop bits and the uart_rx_parity_err flag.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     resetn,
  uart_rx_if.slave rx
);

  localparam int CYCLES_PER_BIT = (1_000_000_000 / BIT_RATE) / (1_000_000_000 / CLK_HZ);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
  localparam int MAX_BITS       = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
  localparam int BIT_W          = $clog2(MAX_BITS + 1);

  // Counter values at which the current period ends (counter starts at 0).
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] PAY_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RECV,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                  r_state;
  logic                    r_sync1;
  logic                    r_rxd_s;
  logic [CNT_W-1:0]        r_cyc_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_stop_err;
  logic                    r_valid;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_frame_err;
  logic                    r_break;
`ifdef UART_RX_PARITY_EN
  logic                    r_par_bit;
  logic                    r_parity_err;
`endif

  logic                    w_bit_tick;
  logic                    w_stop_err;
  logic [PAYLOAD_BITS-1:0] w_shift_next;

  // End of a full bit period since the last sample or state entry.
  assign w_bit_tick   = (r_cyc_cnt == BIT_LAST);
  // Error accumulated over all stop samples, including the current one.
  assign w_stop_err   = r_stop_err | ~r_rxd_s;
  // LSB arrives first: shift right so the first bit ends in bit 0.
  assign w_shift_next = {r_rxd_s, r_shift[PAYLOAD_BITS-1:1]};

  // Two-flop synchroniser for the asynchronous RX pin; idles high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= rx.uart_rxd;
      r_rxd_s <= r_sync1;
    end
  end

  // Frame FSM with bit/cycle counters and registered result outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cyc_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_stop_err   <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // Strobe and its qualifiers default low; data holds its last value.
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_cyc_cnt  <= '0;
          r_bit_cnt  <= '0;
          r_stop_err <= 1'b0;
          if (rx.uart_rx_en && !r_rxd_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_cyc_cnt == HALF_LAST) begin
            r_cyc_cnt <= '0;
            // Still low at mid-start: genuine start bit; otherwise a glitch.
            r_state   <= r_rxd_s ? S_IDLE : S_RECV;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
          end
        end

        S_RECV: begin
          if (w_bit_tick) begin
            r_cyc_cnt <= '0;
            r_shift   <= w_shift_next;
            if (r_bit_cnt == PAY_LAST) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_tick) begin
            r_cyc_cnt <= '0;
            r_par_bit <= r_rxd_s;
            r_state   <= S_STOP;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (w_bit_tick) begin
            r_cyc_cnt <= '0;
            if (r_bit_cnt == STOP_LAST) begin
              // Last stop sample: deliver the frame, errors included.
              r_bit_cnt    <= '0;
              r_stop_err   <= 1'b0;
              r_state      <= S_IDLE;
              r_valid      <= 1'b1;
              r_data       <= r_shift;
              r_frame_err  <= w_stop_err;
              r_break      <= w_stop_err && (r_shift == '0);
`ifdef UART_RX_PARITY_EN
              r_parity_err <= (^r_shift) ^ r_par_bit;
`endif
            end else begin
              r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
              r_stop_err <= w_stop_err;
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx.uart_rx_valid      = r_valid;
  assign rx.uart_rx_data       = r_data;
  assign rx.uart_rx_frame_err  = r_frame_err;
  assign rx.uart_rx_break      = r_break;
`ifdef UART_RX_PARITY_EN
  assign rx.uart_rx_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 1 MHz clock / 100 kbit/s
// (10 cycles per bit). Frames are serialised by the bench; the expected
// result of every frame is queued when it is driven and compared when the
// receiver strobes valid.
module tb_uart_rx;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 100_000;
  localparam int PB       = 8;
  localparam int SB       = 1;
  localparam int CPB      = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + PB + PAR_BITS + SB;
  // 2 sync + half bit + remaining bits + 1 output register
  localparam int LATENCY    = 2 + CPB / 2 + (PB + PAR_BITS + SB) * CPB + 1;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       brk;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] payload;
    logic       stop_val;
    int         gap_bits;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;

  int   tests          = 0;
  int   failed         = 0;
  int   n_valid        = 0;
  int   qual_bad       = 0;
  int   last_valid_cyc = -1000;
  int   start_cyc      = 0;
  exp_t sb[$];

  uart_rx_if #(.PAYLOAD_BITS(PB)) vif ();

  uart_rx #(
    .BIT_RATE    (BIT_RATE),
    .CLK_HZ      (CLK_HZ),
    .PAYLOAD_BITS(PB),
    .STOP_BITS   (SB)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .rx    (vif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_window(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn && !vif.uart_rx_valid && (vif.uart_rx_frame_err || vif.uart_rx_break))
      qual_bad++;
    if (vif.uart_rx_valid) begin
      exp_t e;
      n_valid++;
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_valid: got valid with data=0x%02h, required no valid", vif.uart_rx_data);
      end else begin
        e = sb.pop_front();
        check("rx_data", int'(vif.uart_rx_data), int'(e.data));
        check("rx_frame_err", int'(vif.uart_rx_frame_err), int'(e.ferr));
        check("rx_break", int'(vif.uart_rx_break), int'(e.brk));
`ifdef UART_RX_PARITY_EN
        check("rx_parity_err", int'(vif.uart_rx_parity_err), int'(e.perr));
`endif
        $display("[TB] frame @%0d data=0x%02h ferr=%0b brk=%0b", cyc, vif.uart_rx_data,
                 vif.uart_rx_frame_err, vif.uart_rx_break);
      end
    end
  end

  // Drive one bit period; entered and left 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    vif.uart_rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] payload, input logic stop_val, input logic par_bit,
                            input bit push, input logic exp_ferr, input logic exp_brk);
    if (push) sb.push_back('{payload, exp_ferr, exp_brk, (^payload) ^ par_bit});
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < PB; i++) drive_bit(payload[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    for (int i = 0; i < SB; i++) drive_bit(stop_val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   nv;
    vecs[0] = '{8'hA5, 1'b1, 4, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 1'b0};  // back-to-back with next
    vecs[2] = '{8'hFF, 1'b1, 4, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 4, 1'b1, 1'b0};  // stop bit low

    vif.uart_rxd   = 1'b1;
    vif.uart_rx_en = 1'b1;
    resetn         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(vif.uart_rx_valid), 0);
    check("reset_data", int'(vif.uart_rx_data), 0);
    check("reset_frame_err", int'(vif.uart_rx_frame_err), 0);
    check("reset_break", int'(vif.uart_rx_break), 0);
    resetn = 1'b1;
    idle_bits(2);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].payload, vecs[i].stop_val, ^vecs[i].payload, 1'b1,
                 vecs[i].exp_ferr, vecs[i].exp_brk);
      idle_bits(vecs[i].gap_bits);
      if (i == 0) check_window("latency_a5", last_valid_cyc - start_cyc, LATENCY - 1, LATENCY + 1);
    end

    // Short low glitch while idle must be rejected
    nv = n_valid;
    vif.uart_rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vif.uart_rxd = 1'b1;
    idle_bits(3);
    check("glitch_no_valid", n_valid, nv);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b1, 1'b0, 1'b0);
    idle_bits(4);

    // Break: line low for 2 frame lengths (20 bit times without parity);
    // enable dropped during the second frame so no third frame starts.
    nv = n_valid;
    sb.push_back('{8'h00, 1'b1, 1'b1, 1'b0});
    sb.push_back('{8'h00, 1'b1, 1'b1, 1'b0});
    vif.uart_rxd = 1'b0;
    fork
      begin
        repeat (2 * FRAME_BITS * CPB) @(posedge clk);
      end
      begin
        repeat (15 * CPB) @(posedge clk);
        #1;
        vif.uart_rx_en = 1'b0;
      end
    join
    #1;
    vif.uart_rxd = 1'b1;
    idle_bits(3);
    check("break_frame_count", n_valid - nv, 2);
    vif.uart_rx_en = 1'b1;
    idle_bits(2);

    // Disabled receiver ignores a whole frame
    vif.uart_rx_en = 1'b0;
    nv = n_valid;
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0, 1'b0, 1'b0);
    idle_bits(3);
    check("en0_no_valid", n_valid, nv);
    vif.uart_rx_en = 1'b1;
    idle_bits(1);

    // Enable dropped mid-frame: frame still completes
    fork
      send_frame(8'h55, 1'b1, ^8'h55, 1'b1, 1'b0, 1'b0);
      begin
        repeat (5 * CPB) @(posedge clk);
        #1;
        vif.uart_rx_en = 1'b0;
      end
    join
    idle_bits(3);
    vif.uart_rx_en = 1'b1;
    idle_bits(1);

    // Reset pulsed mid-payload (remaining bits are all high)
    nv = n_valid;
    fork
      send_frame(8'hFF, 1'b1, ^8'hFF, 1'b0, 1'b0, 1'b0);
      begin
        repeat (4 * CPB) @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_valid", int'(vif.uart_rx_valid), 0);
        check("midreset_data", int'(vif.uart_rx_data), 0);
        check("midreset_frame_err", int'(vif.uart_rx_frame_err), 0);
        check("midreset_break", int'(vif.uart_rx_break), 0);
        resetn = 1'b1;
      end
    join
    idle_bits(3);
    check("midreset_no_valid", n_valid, nv);
    send_frame(8'h12, 1'b1, ^8'h12, 1'b1, 1'b0, 1'b0);
    idle_bits(3);

`ifdef UART_RX_PARITY_EN
    // Odd total parity: payload 0x07 with parity bit 0
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_bits(3);
`endif

    for (int k = 0; k < 500 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("frames_outstanding", sb.size(), 0);
    check("flags_outside_valid", qual_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: serial-to-parallel counterpart of the UART transmitter.
- Synchronises the asynchronous uart_rxd pin and detects a start bit.
- Samples each bit at its centre and presents the received payload as a one-cycle valid strobe with error flags.
- Sits between the board RX pin and the host-side consumer logic, using the same bit-rate/clock parameterisation as the transmitter.

Parameters:
BIT_RATE, 9600, line bit rate in bit/s
CLK_HZ, 50_000_000, clk frequency in Hz
PAYLOAD_BITS, 8, data bits per frame
STOP_BITS, 1, stop bits per frame
Derived (localparams):
- CYCLES_PER_BIT = (1_000_000_000/BIT_RATE)/(1_000_000_000/CLK_HZ), integer division; 5208 at defaults.
- HALF_BIT = CYCLES_PER_BIT/2.
- Counter width = 1+$clog2(CYCLES_PER_BIT).

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
uart_rxd  input  1  UART receive pin, idle high, asynchronous to clk
uart_rx_en  input  1  enables detection of new start bits
uart_rx_valid  output  1  one-cycle strobe: a frame completed
uart_rx_data  output  PAYLOAD_BITS  received payload, LSB first on line
uart_rx_frame_err  output  1  qualified by valid: a stop bit sampled low
uart_rx_break  output  1  qualified by valid: frame error with all-zero payload

Behaviour:
- Reset (async, resetn=0):
  - Synchroniser flops = 1; FSM = IDLE; counters = 0.
  - uart_rx_data = 0; uart_rx_valid, uart_rx_frame_err and uart_rx_break = 0.
- Input path: uart_rxd passes through a 2-flop synchroniser; rxd_s (second flop) is the only value used by the FSM.
- FSM states: IDLE, START, RECV, STOP. Cycle counter clears on every state change and on every bit sample.
  - IDLE: if uart_rx_en=1 and rxd_s=0, go to START.
  - START: count cycles. When the counter reaches HALF_BIT:
    - rxd_s=0: go to RECV (mid-start reference point).
    - rxd_s=1: glitch; return to IDLE with no output activity.
  - RECV: sample rxd_s each time the counter reaches CYCLES_PER_BIT.
    - Shift right with the sample into the MSB, so the first line bit ends up in bit 0.
    - After PAYLOAD_BITS samples, go to STOP.
  - STOP: sample each CYCLES_PER_BIT. Any stop sample = 0 sets an internal error flag. After STOP_BITS samples, return to IDLE.
- Output timing:
  - uart_rx_valid goes high for exactly one cycle, in the cycle after the last stop sample.
  - uart_rx_data updates in that same cycle and holds until the next valid; it is never cleared except by reset.
  - frame_err and break are valid only while uart_rx_valid=1 and are 0 otherwise.
  - A frame with a frame error is still delivered (valid=1, data as sampled).
- Latency: valid is asserted 2 (sync) + HALF_BIT + (PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT + 1 cycles after the falling edge at the pin, ±1 cycle of synchroniser uncertainty.
- uart_rx_en deasserted mid-frame: the frame completes normally; enable gates only the IDLE→START transition.
- Back-to-back frames: the FSM is in IDLE from mid-stop-bit onwards, so a start edge immediately following the stop bit is caught.
- Line held low in IDLE (break): after the error frame is delivered, IDLE sees rxd_s=0 and starts a new frame. Each break-length low period yields repeated frames with frame_err=1 and break=1.
- Reset asserted mid-frame: immediate return to reset values; no valid strobe for the partial frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between RECV and STOP that samples one bit at CYCLES_PER_BIT.
  - Adds output port uart_rx_parity_err (1 bit, qualified by valid): 1 when the XOR of the payload bits and the parity bit is 1 (even parity expected).
  - Latency grows by CYCLES_PER_BIT.
- Not defined: no PARITY state, no uart_rx_parity_err port; frame is start + payload + stop only.

Test Plan:
All scenarios use CLK_HZ=1_000_000 and BIT_RATE=100_000, giving CYCLES_PER_BIT=10.
1. Reset, drive frame 0xA5 with one stop bit high, en=1 -> one valid pulse, data=0xA5, frame_err=0, break=0; valid ~98 cycles after the start edge.
2. Two back-to-back frames 0x00 then 0xFF, no idle gap -> two valid pulses, data 0x00 then 0xFF, no errors.
3. 3-cycle low glitch on uart_rxd while idle -> no valid pulse, FSM back in IDLE; a following 0x3C frame is received correctly.
4. Frame 0x81 with stop bit driven low -> valid=1, data=0x81, frame_err=1, break=0. Then hold the line low for 20 bit times -> valid with data=0x00, frame_err=1, break=1.
5. en=0 while frame 0x55 is sent -> no valid. en deasserted midway through frame 0x55 started with en=1 -> valid, data=0x55.
6. resetn pulsed low mid-payload -> outputs at reset values, no valid; the next 0x12 frame is received correctly. With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err=1.
